serial_addsub: RTL and testbench

Bit-serial adder/subtractor for the lab board datapath. It is the subtracting, sequential counterpart to the team's parallel ripple-carry adder. It latches two WIDTH-bit operands on a start request and processes one bit per clock through a single full-adder cell with a registered carry. After WIDTH cycles it presents the sum or difference, carry/borrow and signed overflow. Operands normally come from SW; results drive LEDR.

---
 rtl/serial_addsub.sv | 115 +++++++++++
 tb/tb_serial_addsub.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder cell with a registered carry,
// processing WIDTH operand bits LSB first and reporting sum, carry and overflow.
module serial_addsub #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic             carry_r;
  logic [CNT_W-1:0] cnt_r;

  logic             s_bit;
  logic             c_next;
  logic [WIDTH-1:0] next_sum;

  // Full-adder cell on the current LSBs and the sum register with this bit shifted into its MSB
  always_comb begin
    s_bit    = 1'b0;
    c_next   = 1'b0;
    next_sum = {WIDTH{1'b0}};
    s_bit    = a_sr[0] ^ b_sr[0] ^ carry_r;
    c_next   = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry_r) | (b_sr[0] & carry_r);
    next_sum = (sum_sr >> 1) | {s_bit, {(WIDTH-1){1'b0}}};
  end

  // Control FSM, serial datapath and registered outputs
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
      a_sr    <= {WIDTH{1'b0}};
      b_sr    <= {WIDTH{1'b0}};
      sum_sr  <= {WIDTH{1'b0}};
      carry_r <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
      result  <= {WIDTH{1'b0}};
      cout    <= 1'b0;
      ovf     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            // Subtraction is A + ~B + 1, so the inverted B and forced carry-in are set up here
            a_sr    <= a;
            b_sr    <= sub ? ~b : b;
            carry_r <= sub ? 1'b1 : cin;
            cnt_r   <= {CNT_W{1'b0}};
            busy    <= 1'b1;
            state_r <= ST_RUN;
          end else begin
            busy    <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          sum_sr  <= next_sum;
          carry_r <= c_next;
          cnt_r   <= cnt_r + CNT_W'(1);
          if (cnt_r == LAST_BIT) begin
            // carry_r is the carry into the MSB at this point
            result  <= next_sum;
            cout    <= c_next;
            ovf     <= carry_r ^ c_next;
            busy    <= 1'b0;
            done    <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            busy    <= 1'b1;
            done    <= 1'b0;
            state_r <= ST_RUN;
          end
        end
        ST_DONE: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: directed vector table, protocol sequences and a
// randomized run against an integer-arithmetic reference model.
module tb_serial_addsub;

  localparam int W = 4;

  logic         clock;
  logic         resetn;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;
  logic         busy;
  logic         done;

  int pass_cnt = 0;
  int total_cnt = 0;

  serial_addsub #(.WIDTH(W)) dut (
    .clock(clock), .resetn(resetn), .start(start), .sub(sub),
    .a(a), .b(b), .cin(cin),
    .result(result), .cout(cout), .ovf(ovf), .busy(busy), .done(done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         cin;
    logic [W-1:0] res;
    logic         cout;
    logic         ovf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: plain integer arithmetic, signed range test for overflow.
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic msub,
                       input logic mcin, output logic [W-1:0] r, output logic c, output logic v);
    int ua, ub, sa, sb, full, sres;
    ua = int'(ma);
    ub = int'(mb);
    sa = ma[W-1] ? ua - (1 << W) : ua;
    sb = mb[W-1] ? ub - (1 << W) : ub;
    if (msub) begin
      full = ua + ((1 << W) - 1 - ub) + 1;
      sres = sa - sb;
    end else begin
      full = ua + ub + int'(mcin);
      sres = sa + sb + int'(mcin);
    end
    r = full[W-1:0];
    c = full[W];
    v = (sres > (1 << (W-1)) - 1) || (sres < -(1 << (W-1)));
  endtask

  // One operation; inputs scrambled after the start edge, outputs observed for 10 cycles.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tsub,
                        input logic tcin, output logic [W-1:0] r, output logic c,
                        output logic v, output int busy_n, output int done_n,
                        output int done_at, output int overlap);
    @(negedge clock);
    a = ta; b = tb; sub = tsub; cin = tcin; start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); sub = 1'($urandom); cin = 1'($urandom);
    busy_n = 0; done_n = 0; done_at = -1; overlap = 0;
    r = '0; c = 1'b0; v = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        done_at = k;
        r = result; c = cout; v = ovf;
        if (busy) overlap++;
      end
      // a stray start in RUN must be ignored
      if (k == 2) start = 1'b1;
      if (k == 3) start = 1'b0;
    end
  endtask

  vec_t vecs[9];

  initial begin
    logic [W-1:0] r;
    logic         c, v;
    logic [W-1:0] er;
    logic         ec, ev;
    int           bn, dn, da, ov;
    int           done_idx[$];
    int           seen_done;

    vecs[0] = '{4'b0101, 4'b0011, 1'b0, 1'b0, 4'b1000, 1'b0, 1'b1};
    vecs[1] = '{4'b0111, 4'b0011, 1'b1, 1'b1, 4'b0100, 1'b1, 1'b0};
    vecs[2] = '{4'b0011, 4'b0111, 1'b1, 1'b0, 4'b1100, 1'b0, 1'b0};
    vecs[3] = '{4'b1000, 4'b0001, 1'b1, 1'b0, 4'b0111, 1'b1, 1'b1};
    vecs[4] = '{4'b1111, 4'b1111, 1'b0, 1'b1, 4'b1111, 1'b1, 1'b0};
    vecs[5] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0};
    vecs[6] = '{4'b0111, 4'b0001, 1'b0, 1'b0, 4'b1000, 1'b0, 1'b1};
    vecs[7] = '{4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0};
    vecs[8] = '{4'b0000, 4'b0001, 1'b1, 1'b1, 4'b1111, 1'b0, 1'b0};

    resetn = 1'b0; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_outputs", {27'd0, result, cout, ovf, busy, done}, 32'd0);
    @(negedge clock);
    resetn = 1'b1;
    repeat (3) @(negedge clock);
    chk("idle_after_reset", {27'd0, result, cout, ovf, busy, done}, 32'd0);

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin, r, c, v, bn, dn, da, ov);
      chk($sformatf("vec%0d_result", i), 32'(r), 32'(vecs[i].res));
      chk($sformatf("vec%0d_cout", i), 32'(c), 32'(vecs[i].cout));
      chk($sformatf("vec%0d_ovf", i), 32'(v), 32'(vecs[i].ovf));
      chk($sformatf("vec%0d_timing", i), {bn[7:0], dn[7:0], da[7:0], ov[7:0]},
          {8'(W), 8'd1, 8'(W + 1), 8'd0});
    end

    // start held high: one operation every W+2 cycles
    @(negedge clock);
    a = 4'b0001; b = 4'b0010; sub = 1'b0; cin = 1'b0; start = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      if (done) done_idx.push_back(k);
    end
    start = 1'b0;
    chk("held_start_done_count", 32'(done_idx.size()), 32'd3);
    if (done_idx.size() == 3) begin
      chk("held_start_first_done", 32'(done_idx[0]), 32'(W + 1));
      chk("held_start_period_1", 32'(done_idx[1] - done_idx[0]), 32'(W + 2));
      chk("held_start_period_2", 32'(done_idx[2] - done_idx[1]), 32'(W + 2));
    end
    chk("held_start_result", 32'(result), 32'd3);
    repeat (8) @(negedge clock);

    // reset asserted during the second RUN cycle aborts and clears everything
    a = 4'b0110; b = 4'b0101; sub = 1'b0; cin = 1'b1; start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    @(posedge clock);
    #2;
    resetn = 1'b0;
    #1;
    chk("midrun_reset_outputs", {27'd0, result, cout, ovf, busy, done}, 32'd0);
    @(negedge clock);
    resetn = 1'b1;
    seen_done = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (done) seen_done++;
    end
    chk("midrun_reset_no_done", 32'(seen_done), 32'd0);
    chk("midrun_reset_result", 32'(result), 32'd0);

    // randomized operations against the reference model
    for (int n = 0; n < 40; n++) begin
      logic [W-1:0] ra, rb;
      logic         rs, rc;
      ra = W'($urandom); rb = W'($urandom);
      rs = 1'($urandom); rc = 1'($urandom);
      model(ra, rb, rs, rc, er, ec, ev);
      run_op(ra, rb, rs, rc, r, c, v, bn, dn, da, ov);
      chk($sformatf("rand%0d_out a=%0h b=%0h sub=%0b cin=%0b", n, ra, rb, rs, rc),
          {26'd0, r, c, v}, {26'd0, er, ec, ev});
      chk($sformatf("rand%0d_timing", n), {bn[7:0], dn[7:0], da[7:0], ov[7:0]},
          {8'(W), 8'd1, 8'(W + 1), 8'd0});
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
